magnetron_ctrl: RTL
===================

MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

Interface
REQ-001 Parameter PWR_W, default 4: width of power_level.
REQ-002 Parameter PERIOD, default 10: duty window length in clk cycles, 2..2**16.
REQ-003 Parameter HOLDOFF, default 5: minimum off cycles after shutdown before re-arm, 1..2**16.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low.
REQ-006 set  input  1  start request, level-sampled each edge.
REQ-007 reset  input  1  stop request, level-sampled each edge.
REQ-008 door_open  input  1  interlock; 1 = door open.
REQ-009 power_level  input  PWR_W  on-cycles per window; sampled every edge.
REQ-010 mag_on  output  1  magnetron drive, registered.
REQ-011 active  output  1  latched run request, registered.
REQ-012 holdoff_busy  output  1  high while the re-arm holdoff counter is nonzero, registered.

Function
REQ-013 Latch priority per edge SHALL be: door_open or reset -> clear active; else set, with holdoff idle -> set active; else hold.
REQ-014 set=1 and reset=1 together SHALL clear active (reset wins).
REQ-015 door_open=1 SHALL clear active and force mag_on=0 on the same edge, regardless of set.
REQ-016 Duty counter cnt SHALL run 0..PERIOD-1 and wrap to 0 while active=1.
REQ-017 cnt SHALL be 0 on the edge where active goes 0->1; it SHALL be held at 0 while active=0.
REQ-018 mag_on SHALL be registered as (next active) AND (next cnt < power_level), so mag_on rises on the same edge as active.
REQ-019 power_level=0 SHALL keep mag_on=0 while active=1.
REQ-020 power_level>=PERIOD SHALL saturate to continuous on, with no gap at the wrap.
REQ-021 power_level changes SHALL take effect on the next edge; the window phase SHALL not restart.
REQ-022 On the edge where active goes 1->0, the holdoff counter SHALL load HOLDOFF and decrement by 1 per edge to 0.
REQ-023 While the holdoff counter is nonzero, set SHALL be ignored; holdoff_busy=1.
REQ-024 set held high through holdoff SHALL re-arm active on the first edge after the counter reaches 0.
REQ-025 reset or door_open during holdoff SHALL not reload or extend the counter.
REQ-026 Counter widths SHALL be $clog2(PERIOD) and $clog2(HOLDOFF+1); comparisons SHALL be zero-extended with no truncation of power_level.

Reset
REQ-027 rst_n=0 at an edge SHALL force active=0, mag_on=0, cnt=0, holdoff counter=0, holdoff_busy=0.
REQ-028 Reset mid-run SHALL not start holdoff; set is accepted on the first edge with rst_n=1.
REQ-029 No output SHALL be X after the first reset edge.

Configuration
REQ-030 Macro MAGNETRON_HOLDOFF_EN defined: holdoff per REQ-022..025 is compiled in.
REQ-031 Macro MAGNETRON_HOLDOFF_EN undefined: no holdoff logic; holdoff_busy tied 0; set is accepted on any edge, including the edge after a clear.

Verification (PWR_W=4, PERIOD=10, HOLDOFF=5, macro defined unless stated)
REQ-032 Reset, then set=1 for 1 cycle with power_level=3 -> active=1; mag_on high 3 cycles, low 7 cycles, repeating every 10 cycles.
REQ-033 set=1 and reset=1 on the same edge while active -> active=0, mag_on=0, holdoff_busy=1 for 5 cycles.
REQ-034 After the REQ-033 clear, set=1 held -> active stays 0 for 5 edges, then rises on the 6th edge with cnt=0.
REQ-035 door_open=1 with set=1 at cnt=1 -> mag_on=0 and active=0 on that edge; re-arm only after door_open=0 and holdoff expires.
REQ-036 power_level=15 -> mag_on constant 1 across the wrap; power_level=0 -> mag_on constant 0 with active=1.
REQ-037 Macro undefined: clear then set on the next edge -> active=1 immediately; holdoff_busy never 1.

Source files
------------

// File: rtl/magnetron_ctrl.sv
// Magnetron duty-cycle controller: latched run request, windowed PWM drive,
// door interlock. Optional re-arm holdoff enabled by MAGNETRON_HOLDOFF_EN.
module magnetron_ctrl #(
  parameter int PWR_W   = 4,
  parameter int PERIOD  = 10,
  parameter int HOLDOFF = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             reset,
  input  logic             door_open,
  input  logic [PWR_W-1:0] power_level,
  output logic             mag_on,
  output logic             active,
  output logic             holdoff_busy
);

  localparam int CW = $clog2(PERIOD);
  localparam int XW = (CW > PWR_W) ? CW : PWR_W;

  logic          active_q, active_d;
  logic          mag_on_q, mag_on_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_idle;

  always_comb begin
    active_d = active_q;
    if (door_open || reset) begin
      active_d = 1'b0;
    end else if (set && hold_idle) begin
      active_d = 1'b1;
    end
  end

  // Window restarts at 0 on the arming edge; phase kept across level changes.
  always_comb begin
    cnt_d = '0;
    if (active_d && active_q) begin
      if (cnt_q == CW'(PERIOD - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mag_on_d = active_d && (XW'(cnt_d) < XW'(power_level));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      mag_on_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      mag_on_q <= mag_on_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef MAGNETRON_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          busy_q, busy_d;

  // Only a run-to-stop transition loads; later clears do not extend it.
  always_comb begin
    hold_d = hold_q;
    if (active_q && !active_d) begin
      hold_d = HW'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    busy_d = (hold_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      busy_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      busy_q <= busy_d;
    end
  end

  assign hold_idle    = (hold_q == '0);
  assign holdoff_busy = busy_q;
`else
  logic unused_holdoff;

  assign unused_holdoff = (HOLDOFF != 0);
  assign hold_idle      = 1'b1;
  assign holdoff_busy   = 1'b0;
`endif

  assign active = active_q;
  assign mag_on = mag_on_q;

endmodule
